// File: rtl/ram_1port_ctrl.sv
// ram_1port_ctrl
// Burst controller in front of a single-port RAM. A command names a start
// address and a beat count. Write beats pass straight through to the RAM
// port on their handshake. Read beats are captured into a one-entry output
// register that holds its value while downstream stalls.
// Addresses wrap modulo 2^ADDR_W.

module ram_1port_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;
  logic              slot_free;
  logic              last_beat;

  // Handshake decodes and RAM port wiring; the RAM address always follows cur_addr
  always_comb begin
    cmd_ready   = (state == ST_IDLE);
    wdata_ready = (state == ST_WRITE);
    ram_enb     = (state == ST_WRITE) && wdata_valid;
    ram_addr    = cur_addr;
    ram_wdata   = wdata;
    slot_free   = !rdata_valid || rdata_ready;
    last_beat   = (beats_left == '0);
  end

  // Burst sequencer: command latch, beat counting, read capture and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cur_addr   <= cmd_addr;
            beats_left <= cmd_len;
            state      <= cmd_wr ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (wdata_valid) begin
            cur_addr   <= cur_addr + ADDR_W'(1);
            beats_left <= beats_left - LEN_W'(1);
            if (last_beat) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (slot_free) begin
            rdata       <= ram_rdata;
            rdata_valid <= 1'b1;
            cur_addr    <= cur_addr + ADDR_W'(1);
            beats_left  <= beats_left - LEN_W'(1);
            if (last_beat) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (slot_free) begin
            rdata_valid <= 1'b0;
            state       <= ST_DONE;
            done        <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_1port_ctrl.sv
// tb_ram_1port_ctrl
// Directed bench for ram_1port_ctrl with a behavioural 128x4 RAM attached.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.

module tb_ram_1port_ctrl;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 4;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata = '0;
  logic              rdata_valid;
  logic              rdata_ready = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              ram_enb;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              mem_clear = 1'b0;
  logic [DATA_W-1:0] mem [128];

  int checks   = 0;
  int failures = 0;

  ram_1port_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .done       (done),
    .ram_enb    (ram_enb),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Behavioural single-port RAM: combinational read, write on posedge when enabled
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 4'hF;
    end else if (ram_enb) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer a command for one clock; returns on the falling edge after acceptance
  task automatic issue_cmd(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
    mem_clear = 1'b1;
    repeat (2) @(negedge clk);
    mem_clear = 1'b0;
    #1;
    checks++; if (ram_enb !== 1'b0) begin failures++; $display("[TB] FAIL reset_ram_enb: got %b expected 0", ram_enb); end
    checks++; if (ram_addr !== 7'd0) begin failures++; $display("[TB] FAIL reset_ram_addr: got %0d expected 0", ram_addr); end
    checks++; if (rdata_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdata_valid: got %b expected 0", rdata_valid); end
    checks++; if (rdata !== 4'd0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (wdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_wdata_ready: got %b expected 0", wdata_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_write_burst;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    issue_cmd(1'b1, 7'd5, 4'd3);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1'b1;
      wdata       = DATA_W'(i + 1);
      exp_addr    = ADDR_W'(5 + i);
      #1;
      checks++; if (ram_enb !== 1'b1) begin failures++; $display("[TB] FAIL wr_enb beat%0d: got %b expected 1", i, ram_enb); end
      checks++; if (ram_addr !== exp_addr) begin failures++; $display("[TB] FAIL wr_addr beat%0d: got %0d expected %0d", i, ram_addr, exp_addr); end
      checks++; if (wdata_ready !== 1'b1) begin failures++; $display("[TB] FAIL wr_ready beat%0d: got %b expected 1", i, wdata_ready); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_cmd_ready beat%0d: got %b expected 0", i, cmd_ready); end
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL wr_done: got %b expected 1", done); end
    checks++; if (ram_enb !== 1'b0) begin failures++; $display("[TB] FAIL wr_enb_after: got %b expected 0", ram_enb); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_cmd_ready_done: got %b expected 0", cmd_ready); end
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL wr_done_one_cycle: got %b expected 0", done); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL wr_back_idle: got %b expected 1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      exp_data = DATA_W'(i + 1);
      checks++; if (mem[5 + i] !== exp_data) begin failures++; $display("[TB] FAIL wr_mem[%0d]: got %h expected %h", 5 + i, mem[5 + i], exp_data); end
    end
    @(negedge clk);
  endtask

  task automatic test_read_burst;
    logic [DATA_W-1:0] exp_data;
    rdata_ready = 1'b1;
    issue_cmd(1'b0, 7'd5, 4'd3);
    #1;
    checks++; if (rdata_valid !== 1'b0) begin failures++; $display("[TB] FAIL rd_entry_valid: got %b expected 0", rdata_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      exp_data = DATA_W'(i + 1);
      checks++; if (rdata_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_valid beat%0d: got %b expected 1", i, rdata_valid); end
      checks++; if (rdata !== exp_data) begin failures++; $display("[TB] FAIL rd_data beat%0d: got %h expected %h", i, rdata, exp_data); end
      checks++; if (ram_enb !== 1'b0) begin failures++; $display("[TB] FAIL rd_no_write beat%0d: got %b expected 0", i, ram_enb); end
    end
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rd_done: got %b expected 1", done); end
    checks++; if (rdata_valid !== 1'b0) begin failures++; $display("[TB] FAIL rd_valid_cleared: got %b expected 0", rdata_valid); end
    @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_back_idle: got %b expected 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_read_stall;
    logic [DATA_W-1:0] got [$];
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic              seen_done  = 1'b0;
    logic [DATA_W-1:0] exp_data;
    issue_cmd(1'b0, 7'd5, 4'd3);
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      rdata_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      if (prev_stall) begin
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== prev_data) begin
          failures++;
          $display("[TB] FAIL stall_hold cyc%0d: got valid=%b data=%h expected valid=1 data=%h", cyc, rdata_valid, rdata, prev_data);
        end
      end
      if (done === 1'b1) seen_done = 1'b1;
      if (rdata_valid === 1'b1 && rdata_ready) got.push_back(rdata);
      prev_stall = (rdata_valid === 1'b1) && !rdata_ready;
      prev_data  = rdata;
      @(negedge clk);
    end
    rdata_ready = 1'b1;
    checks++; if (seen_done !== 1'b1) begin failures++; $display("[TB] FAIL stall_done_timeout: got %b expected 1", seen_done); end
    checks++; if (got.size() != 4) begin failures++; $display("[TB] FAIL stall_beat_count: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_data = DATA_W'(i + 1);
      if (i < got.size()) begin
        checks++; if (got[i] !== exp_data) begin failures++; $display("[TB] FAIL stall_order beat%0d: got %h expected %h", i, got[i], exp_data); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [DATA_W-1:0] vals [3];
    logic [ADDR_W-1:0] addrs [3];
    vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC;
    addrs[0] = 7'd126; addrs[1] = 7'd127; addrs[2] = 7'd0;
    issue_cmd(1'b1, 7'd126, 4'd2);
    for (int i = 0; i < 3; i++) begin
      wdata_valid = 1'b1;
      wdata       = vals[i];
      #1;
      checks++; if (ram_addr !== addrs[i]) begin failures++; $display("[TB] FAIL wrap_addr beat%0d: got %0d expected %0d", i, ram_addr, addrs[i]); end
      checks++; if (ram_enb !== 1'b1) begin failures++; $display("[TB] FAIL wrap_enb beat%0d: got %b expected 1", i, ram_enb); end
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL wrap_wr_done: got %b expected 1", done); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[addrs[i]] !== vals[i]) begin failures++; $display("[TB] FAIL wrap_mem[%0d]: got %h expected %h", addrs[i], mem[addrs[i]], vals[i]); end
    end
    rdata_ready = 1'b1;
    issue_cmd(1'b0, 7'd126, 4'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (rdata_valid !== 1'b1 || rdata !== vals[i]) begin failures++; $display("[TB] FAIL wrap_rd beat%0d: got valid=%b data=%h expected valid=1 data=%h", i, rdata_valid, rdata, vals[i]); end
    end
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL wrap_rd_done: got %b expected 1", done); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_write_gaps;
    logic [4:0]        pat;
    logic [DATA_W-1:0] vals [3];
    int                k;
    int                writes;
    pat = 5'b10101;
    vals[0] = 4'h7; vals[1] = 4'h8; vals[2] = 4'h9;
    k = 0;
    writes = 0;
    issue_cmd(1'b1, 7'd20, 4'd2);
    for (int c = 0; c < 5; c++) begin
      wdata_valid = pat[c];
      wdata       = pat[c] ? vals[k] : 4'h5;
      #1;
      checks++; if (ram_enb !== pat[c]) begin failures++; $display("[TB] FAIL gap_enb cyc%0d: got %b expected %b", c, ram_enb, pat[c]); end
      checks++; if (wdata_ready !== 1'b1) begin failures++; $display("[TB] FAIL gap_ready cyc%0d: got %b expected 1", c, wdata_ready); end
      if (ram_enb === 1'b1) writes++;
      if (pat[c]) k++;
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL gap_done: got %b expected 1", done); end
    checks++; if (writes != 3) begin failures++; $display("[TB] FAIL gap_write_count: got %0d expected 3", writes); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[20 + i] !== vals[i]) begin failures++; $display("[TB] FAIL gap_mem[%0d]: got %h expected %h", 20 + i, mem[20 + i], vals[i]); end
    end
    checks++; if (mem[23] !== 4'hF) begin failures++; $display("[TB] FAIL gap_mem[23]: got %h expected f", mem[23]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    issue_cmd(1'b1, 7'd40, 4'd3);
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1;
      wdata       = DATA_W'(i + 1);
      @(negedge clk);
    end
    wdata_valid = 1'b1;
    wdata       = 4'h3;
    rst         = 1'b0;
    #1;
    checks++; if (ram_enb !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_enb: got %b expected 0", ram_enb); end
    checks++; if (ram_addr !== 7'd0) begin failures++; $display("[TB] FAIL mid_rst_addr: got %0d expected 0", ram_addr); end
    checks++; if (wdata_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_wready: got %b expected 0", wdata_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (ram_enb !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_idle_enb: got %b expected 0", ram_enb); end
    wdata_valid = 1'b0;
    checks++; if (mem[40] !== 4'h1 || mem[41] !== 4'h2) begin failures++; $display("[TB] FAIL mid_rst_kept: got %h %h expected 1 2", mem[40], mem[41]); end
    checks++; if (mem[42] !== 4'hF || mem[43] !== 4'hF) begin failures++; $display("[TB] FAIL mid_rst_untouched: got %h %h expected f f", mem[42], mem[43]); end

    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 7'd50;
    cmd_len   = 4'd0;
    @(negedge clk);
    cmd_wr      = 1'b0;
    wdata_valid = 1'b1;
    wdata       = 4'h6;
    rdata_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL held_busy_write: got %b expected 0", cmd_ready); end
    checks++; if (ram_enb !== 1'b1) begin failures++; $display("[TB] FAIL held_write_enb: got %b expected 1", ram_enb); end
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL held_done: got done=%b ready=%b expected done=1 ready=0", done, cmd_ready); end
    @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL held_idle_ready: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0 || rdata_valid !== 1'b0) begin failures++; $display("[TB] FAIL held_read_entry: got ready=%b valid=%b expected 0 0", cmd_ready, rdata_valid); end
    @(negedge clk);
    #1;
    checks++; if (rdata_valid !== 1'b1 || rdata !== 4'h6) begin failures++; $display("[TB] FAIL held_read_data: got valid=%b data=%h expected valid=1 data=6", rdata_valid, rdata); end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Test sequence
  initial begin
    $display("[TB] starting ram_1port_ctrl bench");
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_stall();
    test_wrap();
    test_write_gaps();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_1port_ctrl.md
RAM_1PORT_CTRL -- requirements
Module: ram_1port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, RAM address width (128 words).
REQ-002 Parameter DATA_W, default 4, RAM word width.
REQ-003 Parameter LEN_W, default 4, burst length field width; beats = cmd_len+1 (1..16).
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  burst command offered.
REQ-007 cmd_ready  output  1  controller can accept a command.
REQ-008 cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  input  ADDR_W  burst start address.
REQ-010 cmd_len  input  LEN_W  beats minus one.
REQ-011 wdata_valid  input  1  write beat offered.
REQ-012 wdata_ready  output  1  write beat accepted this cycle if wdata_valid.
REQ-013 wdata  input  DATA_W  write beat data.
REQ-014 rdata_valid  output  1  read beat held on rdata.
REQ-015 rdata_ready  input  1  downstream accepts read beat.
REQ-016 rdata  output  DATA_W  read beat data.
REQ-017 done  output  1  one-cycle pulse at burst completion.
REQ-018 ram_enb  output  1  RAM port enable: 1 = write, 0 = read.
REQ-019 ram_addr  output  ADDR_W  RAM port address.
REQ-020 ram_wdata  output  DATA_W  RAM write data.
REQ-021 ram_rdata  input  DATA_W  RAM read data, combinational from ram_addr while ram_enb=0.

Function
REQ-022 States IDLE, WRITE, READ, DRAIN, DONE; one-hot or encoded, implementer's choice.
REQ-023 IDLE: cmd_ready=1; cmd_valid&cmd_ready at posedge latches cur_addr=cmd_addr, beats_left=cmd_len, goes to WRITE if cmd_wr else READ.
REQ-024 cmd_ready=0 in every state except IDLE; commands offered while busy are held off, never dropped or merged.
REQ-025 ram_addr = cur_addr register at all times; ram_wdata = wdata combinationally.
REQ-026 WRITE: wdata_ready=1; ram_enb = wdata_valid combinationally, so the RAM writes wdata to cur_addr at the same posedge the beat handshake completes.
REQ-027 ram_enb=0 in every state other than WRITE, and in WRITE whenever wdata_valid=0 (no spurious writes).
REQ-028 Per accepted write beat: cur_addr increments; beats_left decrements; beat with beats_left=0 moves to DONE.
REQ-029 READ: rdata slot free when rdata_valid=0 or rdata_ready=1; at posedge with slot free, rdata <= ram_rdata, rdata_valid <= 1, cur_addr increments, beats_left decrements.
REQ-030 First read beat is valid exactly one cycle after entering READ; with rdata_ready held 1, one beat per cycle.
REQ-031 Capture of the beat with beats_left=0 moves READ to DRAIN; DRAIN holds until the final beat is accepted, then DONE.
REQ-032 rdata and rdata_valid hold stable while rdata_valid=1 and rdata_ready=0; rdata_valid clears on acceptance with no new capture.
REQ-033 DONE: done=1 for exactly one cycle, then IDLE; cmd_ready=0 during DONE.
REQ-034 Address arithmetic modulo 2^ADDR_W: cur_addr 127 increments to 0; bursts wrap silently.
REQ-035 wdata_valid, rdata_ready ignored outside WRITE, READ/DRAIN respectively; wdata_ready=0 outside WRITE.

Reset
REQ-036 rst=0 asynchronously forces IDLE, cur_addr=0, beats_left=0, rdata=0, rdata_valid=0, done=0; outputs ram_enb=0, ram_addr=0.
REQ-037 Reset mid-burst aborts it; no RAM write occurs while rst=0; remaining beats are discarded; first cycle after release cmd_ready=1.

Verification
REQ-038 Write burst cmd_addr=5, cmd_len=3, wdata 1,2,3,4 back-to-back -> ram_enb=1 four cycles, addrs 5..8 hold 1..4, done pulse next cycle.
REQ-039 Read burst cmd_addr=5, cmd_len=3, rdata_ready=1 -> rdata_valid four consecutive cycles starting one cycle after READ entry, data 1,2,3,4, then done.
REQ-040 Read with rdata_ready toggled 1,0,0,1,... -> each beat held stable while stalled, no beat lost or duplicated, order preserved.
REQ-041 Write cmd_addr=126, cmd_len=2, wdata A,B,C -> written to 126,127,0; read back same range returns A,B,C.
REQ-042 Write burst with wdata_valid gaps (1,0,1,0,1) -> ram_enb=0 in gap cycles, exactly three RAM writes.
REQ-043 rst=0 after second of four write beats -> outputs reset immediately, addrs beyond second beat unchanged, cmd_ready=1 after release; cmd_valid held during busy is accepted only after done.
